// File: rtl/match_pkg.sv
// Shared types and constants for the tank-game round controller.
// Optional pause support is enabled with the MATCH_CTRL_PAUSE_EN macro.
package match_pkg;

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAYING   = 3'd2,
    CONTINUE  = 3'd3,
    FINAL     = 3'd4,
    PAUSED    = 3'd5
  } match_state_e;

  localparam int SCORE_W = 6;
  localparam int MAP_W   = 2;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Scores stop at the top of their range instead of wrapping to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for one raw button.
// A held button yields a single one-cycle edge pulse.
module btn_edge (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic btn_i,
  output logic edge_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/match_ctrl.sv
// Game-phase sequencer: menu, countdown, playing, continue, final (plus paused
// when MATCH_CTRL_PAUSE_EN is defined). Owns map choice, scores and round reset.
module match_ctrl
  import match_pkg::*;
#(
  parameter int WIN_SCORE       = 5,
  parameter int STEP_FRAMES     = 60,
  parameter int CONTINUE_FRAMES = 120,
  parameter int MAP_COUNT       = 3
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               frame_tick_i,
  input  logic               space_i,
  input  logic               sel_up_i,
  input  logic               sel_down_i,
  input  logic               hit_p1_i,
  input  logic               hit_p2_i,
  output logic               is_menu_o,
  output logic               is_countdown_o,
  output logic               is_playing_o,
  output logic               is_continue_o,
  output logic               is_final_o,
  output logic               round_reset_o,
  output logic               freeze_o,
  output logic [MAP_W-1:0]   map_type_o,
  output logic [1:0]         countdown_o,
  output logic [SCORE_W-1:0] score_p1_o,
  output logic [SCORE_W-1:0] score_p2_o,
  output logic [1:0]         winner_o
);

  localparam int CD_FRAMES = 3 * STEP_FRAMES;
  localparam int CNT_MAX   = (CD_FRAMES > CONTINUE_FRAMES) ? CD_FRAMES : CONTINUE_FRAMES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   CD_LAST   = CNT_W'(CD_FRAMES - 1);
  localparam logic [CNT_W-1:0]   STEP1     = CNT_W'(STEP_FRAMES);
  localparam logic [CNT_W-1:0]   STEP2     = CNT_W'(2 * STEP_FRAMES);
  localparam logic [CNT_W-1:0]   CONT_LAST = CNT_W'(CONTINUE_FRAMES - 1);
  localparam logic [MAP_W-1:0]   MAP_LAST  = MAP_W'(MAP_COUNT - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  logic space_edge, up_edge, down_edge;

  btn_edge u_space (.clk_i(clk_i), .reset_ni(reset_ni), .btn_i(space_i),    .edge_o(space_edge));
  btn_edge u_up    (.clk_i(clk_i), .reset_ni(reset_ni), .btn_i(sel_up_i),   .edge_o(up_edge));
  btn_edge u_down  (.clk_i(clk_i), .reset_ni(reset_ni), .btn_i(sel_down_i), .edge_o(down_edge));

  match_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAP_W-1:0]   map_q, map_d;
  logic [SCORE_W-1:0] score_p1_q, score_p1_d;
  logic [SCORE_W-1:0] score_p2_q, score_p2_d;
  logic [1:0]         winner_q, winner_d;
  logic               round_reset_q, round_reset_d;
  logic               freeze_q, freeze_d;
  logic [1:0]         countdown_q, countdown_d;
  logic               is_menu_q, is_menu_d;
  logic               is_countdown_q, is_countdown_d;
  logic               is_playing_q, is_playing_d;
  logic               is_continue_q, is_continue_d;
  logic               is_final_q, is_final_d;
  logic [SCORE_W-1:0] p1_inc, p2_inc;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    map_d         = map_q;
    score_p1_d    = score_p1_q;
    score_p2_d    = score_p2_q;
    winner_d      = winner_q;
    round_reset_d = 1'b0;
    p1_inc        = sat_inc(score_p1_q);
    p2_inc        = sat_inc(score_p2_q);

    unique case (state_q)
      MENU: begin
        if (down_edge && !up_edge) begin
          map_d = (map_q == MAP_LAST) ? '0 : map_q + MAP_W'(1);
        end else if (up_edge && !down_edge) begin
          map_d = (map_q == '0) ? MAP_LAST : map_q - MAP_W'(1);
        end
        if (space_edge) begin
          score_p1_d    = '0;
          score_p2_d    = '0;
          winner_d      = WIN_NONE;
          round_reset_d = 1'b1;
          cnt_d         = '0;
          state_d       = COUNTDOWN;
        end
      end

      COUNTDOWN: begin
        if (frame_tick_i) begin
          if (cnt_q == CD_LAST) begin
            cnt_d   = '0;
            state_d = PLAYING;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // A simultaneous hit on both tanks is a draw and scores nothing.
      PLAYING: begin
        if (hit_p1_i && hit_p2_i) begin
          cnt_d   = '0;
          state_d = CONTINUE;
        end else if (hit_p1_i) begin
          score_p2_d = p2_inc;
          cnt_d      = '0;
          if (p2_inc == WIN_VAL) begin
            winner_d = WIN_P2;
            state_d  = FINAL;
          end else begin
            state_d = CONTINUE;
          end
        end else if (hit_p2_i) begin
          score_p1_d = p1_inc;
          cnt_d      = '0;
          if (p1_inc == WIN_VAL) begin
            winner_d = WIN_P1;
            state_d  = FINAL;
          end else begin
            state_d = CONTINUE;
          end
        end
`ifdef MATCH_CTRL_PAUSE_EN
        else if (space_edge) begin
          state_d = PAUSED;
        end
`endif
      end

      CONTINUE: begin
        if (space_edge || (frame_tick_i && cnt_q == CONT_LAST)) begin
          cnt_d         = '0;
          round_reset_d = 1'b1;
          state_d       = COUNTDOWN;
        end else if (frame_tick_i) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      FINAL: begin
        if (space_edge) begin
          state_d = MENU;
        end
      end

`ifdef MATCH_CTRL_PAUSE_EN
      PAUSED: begin
        if (space_edge) begin
          state_d = PLAYING;
        end
      end
`endif

      default: begin
        cnt_d   = '0;
        state_d = MENU;
      end
    endcase

    // Outputs are registered from the next-state view so they change with the state.
    is_menu_d      = (state_d == MENU);
    is_countdown_d = (state_d == COUNTDOWN);
    is_playing_d   = (state_d == PLAYING) || (state_d == PAUSED);
    is_continue_d  = (state_d == CONTINUE);
    is_final_d     = (state_d == FINAL);
`ifdef MATCH_CTRL_PAUSE_EN
    freeze_d       = (state_d == PAUSED);
`else
    freeze_d       = 1'b0;
`endif

    countdown_d = 2'd0;
    if (state_d == COUNTDOWN) begin
      if (cnt_d < STEP1) begin
        countdown_d = 2'd3;
      end else if (cnt_d < STEP2) begin
        countdown_d = 2'd2;
      end else begin
        countdown_d = 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= MENU;
      cnt_q          <= '0;
      map_q          <= '0;
      score_p1_q     <= '0;
      score_p2_q     <= '0;
      winner_q       <= WIN_NONE;
      round_reset_q  <= 1'b0;
      freeze_q       <= 1'b0;
      countdown_q    <= 2'd0;
      is_menu_q      <= 1'b1;
      is_countdown_q <= 1'b0;
      is_playing_q   <= 1'b0;
      is_continue_q  <= 1'b0;
      is_final_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      map_q          <= map_d;
      score_p1_q     <= score_p1_d;
      score_p2_q     <= score_p2_d;
      winner_q       <= winner_d;
      round_reset_q  <= round_reset_d;
      freeze_q       <= freeze_d;
      countdown_q    <= countdown_d;
      is_menu_q      <= is_menu_d;
      is_countdown_q <= is_countdown_d;
      is_playing_q   <= is_playing_d;
      is_continue_q  <= is_continue_d;
      is_final_q     <= is_final_d;
    end
  end

  assign is_menu_o      = is_menu_q;
  assign is_countdown_o = is_countdown_q;
  assign is_playing_o   = is_playing_q;
  assign is_continue_o  = is_continue_q;
  assign is_final_o     = is_final_q;
  assign round_reset_o  = round_reset_q;
  assign freeze_o       = freeze_q;
  assign map_type_o     = map_q;
  assign countdown_o    = countdown_q;
  assign score_p1_o     = score_p1_q;
  assign score_p2_o     = score_p2_q;
  assign winner_o       = winner_q;

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Round-sequencing controller for the two-player tank game, in the VGA clock domain. It owns the game-phase state machine: menu, countdown, playing, continue and final. It also handles map selection, per-player scores and the round-reset pulse that re-initialises both tanks and the map. It consumes button inputs, per-frame ticks and the collision unit's player-hit flags. It drives the phase flags used by the RGB renderer and the score overlay.

## Interface
- WIN_SCORE, 5: score that ends the match (1..63).
- STEP_FRAMES, 60: frames per countdown digit (3 digits).
- CONTINUE_FRAMES, 120: frames spent in CONTINUE before auto-advance.
- MAP_COUNT, 3: number of selectable maps (1..4).

- clk_i  in  1  VGA pixel clock.
- reset_ni  in  1  asynchronous, active-low reset.
- frame_tick_i  in  1  one-cycle pulse per frame (start of vsync), synchronous.
- space_i  in  1  raw fire/confirm button.
- sel_up_i  in  1  raw select-up button.
- sel_down_i  in  1  raw select-down button.
- hit_p1_i  in  1  player 1 destroyed this cycle, synchronous.
- hit_p2_i  in  1  player 2 destroyed this cycle, synchronous.
- is_menu_o, is_countdown_o, is_playing_o, is_continue_o, is_final_o  out  1 each  one-hot phase flags.
- round_reset_o  out  1  one-cycle active-high reset pulse to tanks, bullets and map.
- freeze_o  out  1  datapath hold (pause).
- map_type_o  out  2  selected map.
- countdown_o  out  2  digit shown: 3, 2, 1; 0 outside COUNTDOWN.
- score_p1_o, score_p2_o  out  6 each  round wins.
- winner_o  out  2  00 none, 01 P1, 10 P2.

## Operation
- Buttons pass through a 2-flop synchroniser and a rising-edge detector. A held button counts once.
- MENU:
  - sel_down edge: map_type + 1, wrapping MAP_COUNT-1 to 0.
  - sel_up edge: map_type - 1, wrapping 0 to MAP_COUNT-1.
  - Both edges in the same cycle: no change.
  - space edge: clear both scores and winner, pulse round_reset_o, go to COUNTDOWN.
- COUNTDOWN:
  - Frame counter cleared on entry.
  - countdown_o = 3 for the first STEP_FRAMES ticks, 2 for the next STEP_FRAMES, 1 for the next STEP_FRAMES.
  - On tick 3*STEP_FRAMES, go to PLAYING.
  - Buttons and hits are ignored.
- PLAYING, hits sampled every cycle:
  - hit_p1_i only: score_p2 + 1.
  - hit_p2_i only: score_p1 + 1.
  - Both in the same cycle: draw, no score change.
  - After any hit: if the incremented score equals WIN_SCORE, set winner_o and go to FINAL; otherwise go to CONTINUE.
  - Scores saturate at 63.
- CONTINUE:
  - Count CONTINUE_FRAMES ticks, or stop early on a space edge.
  - Then pulse round_reset_o and go to COUNTDOWN.
  - Hits are ignored.
- FINAL:
  - Scores and winner are held.
  - space edge: go to MENU. map_type is retained.
- Hits outside PLAYING are ignored. Hit flags are held by the collision unit; only the first cycle acts, because the state leaves PLAYING.

## Timing
- Reset values:
  - State MENU, so is_menu_o = 1 and all other flags 0.
  - round_reset_o = 0, freeze_o = 0.
  - map_type_o = 0, countdown_o = 0.
  - Scores 0, winner 00.
  - Frame counter 0, synchroniser and edge flops 0.
- Raw button high at edge N: edge detected in the cycle after N+1; state and outputs update at edge N+2.
- hit_p*_i high at edge N: scores, winner and state update at edge N. Visible the same cycle after N.
- round_reset_o is high for exactly the cycle in which the COUNTDOWN flag first reads 1.
- frame_tick_i coincident with a state entry is not counted toward the new state.
- All outputs are registered; no combinational input-to-output paths.
- Reset assertion mid-round returns to MENU immediately and asynchronously.

## Configuration
- MATCH_CTRL_PAUSE_EN defined:
  - Adds a PAUSED state. A space edge in PLAYING goes to PAUSED; a space edge in PAUSED returns to PLAYING.
  - freeze_o = 1 and is_playing_o = 1 while PAUSED.
  - Hits in PAUSED are ignored.
- MATCH_CTRL_PAUSE_EN undefined: space is ignored in PLAYING, and freeze_o is tied 0.

## Structure
- Shared package match_pkg holds:
  - state enum `match_state_e` (MENU, COUNTDOWN, PLAYING, CONTINUE, FINAL, PAUSED).
  - SCORE_W = 6, MAP_W = 2.
  - winner encoding constants.
- One sub-module, btn_edge (synchroniser plus rising-edge detector), instantiated three times.

## Test plan
- Reset, then sel_down pressed 4 times with MAP_COUNT = 3 -> map_type_o = 1; then sel_up pressed twice -> map_type_o = 2.
- MENU, space press -> round_reset_o high for 1 cycle. countdown_o reads 3, then 2, then 1, advancing every 60 frame ticks. PLAYING is entered on tick 180.
- PLAYING, hit_p2_i pulsed -> score_p1_o = 1, CONTINUE entered. After 120 ticks -> round_reset_o pulses and COUNTDOWN is entered.
- PLAYING, hit_p1_i and hit_p2_i in the same cycle -> scores unchanged, CONTINUE entered.
- With score_p2 = 4, hit_p1_i -> score_p2_o = 5, winner_o = 10, FINAL. Then space -> MENU; the next space clears both scores to 0.
- MATCH_CTRL_PAUSE_EN defined: space in PLAYING -> freeze_o = 1 and a hit is ignored. A second space -> freeze_o = 0.
